// File: rtl/lidar_point_filter_pkg.sv
// Shared widths, point record layout and small helpers for the LiDAR point filter.
package lidar_point_filter_pkg;

    localparam int PT_COORD_W = 16;
    localparam int PT_INT_W   = 8;
    localparam int PT_REC_W   = 3 * PT_COORD_W + PT_INT_W;

    // Packing order x, y, z, intens from MSB down.
    typedef struct packed {
        logic [PT_COORD_W-1:0] x;
        logic [PT_COORD_W-1:0] y;
        logic [PT_COORD_W-1:0] z;
        logic [PT_INT_W-1:0]   intens;
    } pt_rec_t;

    // What the S2 stage did with the point leaving S1 this cycle.
    typedef enum logic [2:0] {
        S2_IDLE,
        S2_PUSH,
        S2_DROP_INVAL,
        S2_DROP_ROI,
        S2_DROP_OVF
    } s2_evt_t;

    localparam int CNT_PASS  = 0;
    localparam int CNT_INVAL = 1;
    localparam int CNT_ROI   = 2;
    localparam int CNT_OVF   = 3;

    function automatic logic in_range(
        input logic signed [PT_COORD_W-1:0] v,
        input logic signed [PT_COORD_W-1:0] lo,
        input logic signed [PT_COORD_W-1:0] hi
    );
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/lidar_point_filter_if.sv
// Point stream in (strobe only) and filtered point stream out (valid/ready).
interface lidar_point_filter_if;
    import lidar_point_filter_pkg::*;

    logic                  pt_stb;
    logic [PT_COORD_W-1:0] pt_x;
    logic [PT_COORD_W-1:0] pt_y;
    logic [PT_COORD_W-1:0] pt_z;
    logic [PT_INT_W-1:0]   pt_intens;
    logic                  pt_flag;

    // Output handshake: a point transfers on any rising edge with m_valid & m_ready;
    // m_valid never waits on m_ready, and m_* hold steady while m_valid & ~m_ready.
    logic                  m_valid;
    logic                  m_ready;
    logic [PT_COORD_W-1:0] m_x;
    logic [PT_COORD_W-1:0] m_y;
    logic [PT_COORD_W-1:0] m_z;
    logic [PT_INT_W-1:0]   m_intens;

    modport master (
        output pt_stb, pt_x, pt_y, pt_z, pt_intens, pt_flag, m_ready,
        input  m_valid, m_x, m_y, m_z, m_intens
    );

    modport slave (
        input  pt_stb, pt_x, pt_y, pt_z, pt_intens, pt_flag, m_ready,
        output m_valid, m_x, m_y, m_z, m_intens
    );

endinterface

// File: rtl/lidar_point_filter_sync_fifo_fwft.sv
// First-word-fall-through FIFO: head is read combinationally from storage.
module sync_fifo_fwft #(
    parameter int WIDTH = 56,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             wr_en;
    logic             rd_en;

    // Extra pointer MSB separates full (level == DEPTH) from empty (level == 0).
    assign level = wr_ptr - rd_ptr;
    assign full  = (level == (AW+1)'(DEPTH));
    assign empty = (level == '0);

    // A pop frees the slot in the same edge, so a push at full is legal with a pop.
    assign rd_en = pop & ~empty;
    assign wr_en = push & (~full | rd_en);

    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/lidar_point_filter.sv
// Two-stage LiDAR point filter: S1 registers point and verdict, S2 writes the FIFO or counts a drop.
module lidar_point_filter
    import lidar_point_filter_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    lidar_point_filter_if.slave          pif,
    input  logic                         cfg_en,
    input  logic signed [PT_COORD_W-1:0] cfg_x_min,
    input  logic signed [PT_COORD_W-1:0] cfg_x_max,
    input  logic signed [PT_COORD_W-1:0] cfg_y_min,
    input  logic signed [PT_COORD_W-1:0] cfg_y_max,
    input  logic signed [PT_COORD_W-1:0] cfg_z_min,
    input  logic signed [PT_COORD_W-1:0] cfg_z_max,
    input  logic [PT_INT_W-1:0]          cfg_i_min,
    input  logic                         cnt_clr,
    output logic [$clog2(DEPTH):0]       fifo_level,
    output logic [CNT_W-1:0]             cnt_pass,
    output logic [CNT_W-1:0]             cnt_inval,
    output logic [CNT_W-1:0]             cnt_roi,
    output logic [CNT_W-1:0]             cnt_ovf
);

    logic    roi_ok;
    logic    pass_d;
    logic    s1_vld;
    logic    s1_flag;
    logic    s1_pass;
    pt_rec_t s1_rec;
    pt_rec_t head;
    logic    fifo_full;
    logic    fifo_empty;
    logic    pop;
    logic    push;
    s2_evt_t s2_evt;
    logic [3:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_q [4];

    // cfg_* only matters on the strobe cycle; the verdict is frozen into S1.
    assign roi_ok = in_range(pif.pt_x, cfg_x_min, cfg_x_max)
                  & in_range(pif.pt_y, cfg_y_min, cfg_y_max)
                  & in_range(pif.pt_z, cfg_z_min, cfg_z_max)
                  & (pif.pt_intens >= cfg_i_min);
    assign pass_d = pif.pt_flag & (~cfg_en | roi_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s1_flag <= 1'b0;
            s1_pass <= 1'b0;
            s1_rec  <= '0;
        end else begin
            s1_vld <= pif.pt_stb;
            if (pif.pt_stb) begin
                s1_flag       <= pif.pt_flag;
                s1_pass       <= pass_d;
                s1_rec.x      <= pif.pt_x;
                s1_rec.y      <= pif.pt_y;
                s1_rec.z      <= pif.pt_z;
                s1_rec.intens <= pif.pt_intens;
            end
        end
    end

    assign pop = ~fifo_empty & pif.m_ready;

    // Exactly one outcome per S1 point; drop reasons ranked inval > roi > ovf.
    always_comb begin
        s2_evt = S2_IDLE;
        push   = 1'b0;
        if (s1_vld) begin
            if (s1_pass) begin
                if (~fifo_full | pop) begin
                    s2_evt = S2_PUSH;
                    push   = 1'b1;
                end else begin
                    s2_evt = S2_DROP_OVF;
                end
            end else if (!s1_flag) begin
                s2_evt = S2_DROP_INVAL;
            end else begin
                s2_evt = S2_DROP_ROI;
            end
        end
    end

    always_comb begin
        cnt_inc            = '0;
        cnt_inc[CNT_PASS]  = (s2_evt == S2_PUSH);
        cnt_inc[CNT_INVAL] = (s2_evt == S2_DROP_INVAL);
        cnt_inc[CNT_ROI]   = (s2_evt == S2_DROP_ROI);
        cnt_inc[CNT_OVF]   = (s2_evt == S2_DROP_OVF);
    end

    sync_fifo_fwft #(
        .WIDTH (PT_REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .wr_data (s1_rec),
        .pop     (pop),
        .rd_data (head),
        .level   (fifo_level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign pif.m_valid  = ~fifo_empty;
    assign pif.m_x      = head.x;
    assign pif.m_y      = head.y;
    assign pif.m_z      = head.z;
    assign pif.m_intens = head.intens;

    // Saturating counters; a clear beats an increment in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (cnt_clr) begin
                    cnt_q[i] <= '0;
                end else if (cnt_inc[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign cnt_pass  = cnt_q[CNT_PASS];
    assign cnt_inval = cnt_q[CNT_INVAL];
    assign cnt_roi   = cnt_q[CNT_ROI];
    assign cnt_ovf   = cnt_q[CNT_OVF];

endmodule
